// File: rtl/inst_cache_control.sv
// inst_cache_control: hit/miss sequencing for the 2-way, 8-set instruction
// cache. Hits complete with zero added latency. A miss requests a line fill
// from pmem and writes it into the way that was LRU when the miss was seen.
// Saturating hit/miss counters are kept for performance monitoring.
module inst_cache_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    output logic             mem_resp,
    input  logic             hit_0,
    input  logic             hit_1,
    input  logic             lru,
    output logic             next_lru,
    output logic             load_valid_0,
    output logic             load_valid_1,
    output logic             load_tag_0,
    output logic             load_tag_1,
    output logic             pmem_read,
    input  logic             pmem_resp,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t state;
    logic   victim;
    logic   hit_evt;
    logic   fill_evt;
    logic   any_hit;

    assign any_hit = hit_0 | hit_1;

    // Outputs depend on the current state and the live inputs, so a hit
    // can complete in the same cycle it is requested.
    always_comb begin
        mem_resp     = 1'b0;
        next_lru     = lru;
        load_valid_0 = 1'b0;
        load_valid_1 = 1'b0;
        load_tag_0   = 1'b0;
        load_tag_1   = 1'b0;
        pmem_read    = 1'b0;
        hit_evt      = 1'b0;
        fill_evt     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read && any_hit) begin
                    mem_resp = 1'b1;
                    // hit_0 takes priority if both ways claim a hit.
                    next_lru = hit_0 ? 1'b1 : 1'b0;
                    hit_evt  = 1'b1;
                end
            end
            MISS: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    mem_resp     = 1'b1;
                    next_lru     = ~victim;
                    load_tag_0   = ~victim;
                    load_valid_0 = ~victim;
                    load_tag_1   = victim;
                    load_valid_1 = victim;
                    fill_evt     = 1'b1;
                end
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

    // State and victim-way register; the victim is latched when the miss
    // is detected so later LRU changes cannot redirect the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read && !any_hit) begin
                        victim <= lru;
                        state  <= MISS;
                    end
                end
                MISS: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters; a clear overrides a same-cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (perf_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (fill_evt && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_cache_control.sv
// Directed bench for inst_cache_control. Expected output vectors are queued
// as each step is driven and compared when the outputs are sampled.
module tb_inst_cache_control;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_read = 1'b0;
    logic             mem_resp;
    logic             hit_0 = 1'b0;
    logic             hit_1 = 1'b0;
    logic             lru = 1'b0;
    logic             next_lru;
    logic             load_valid_0;
    logic             load_valid_1;
    logic             load_tag_0;
    logic             load_tag_1;
    logic             pmem_read;
    logic             pmem_resp = 1'b0;
    logic             perf_clr = 1'b0;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    inst_cache_control #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_resp     (mem_resp),
        .hit_0        (hit_0),
        .hit_1        (hit_1),
        .lru          (lru),
        .next_lru     (next_lru),
        .load_valid_0 (load_valid_0),
        .load_valid_1 (load_valid_1),
        .load_tag_0   (load_tag_0),
        .load_tag_1   (load_tag_1),
        .pmem_read    (pmem_read),
        .pmem_resp    (pmem_resp),
        .perf_clr     (perf_clr),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    logic [6:0] outv;
    assign outv = {mem_resp, next_lru, load_valid_0, load_valid_1,
                   load_tag_0, load_tag_1, pmem_read};

    typedef struct {
        string      tag;
        logic [6:0] exp;
        logic [6:0] mask;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic logic [6:0] ov(input logic mr, input logic nl,
                                      input logic lv0, input logic lv1,
                                      input logic lt0, input logic lt1,
                                      input logic pr);
        return {mr, nl, lv0, lv1, lt0, lt1, pr};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the inputs just driven, compare at the
    // falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [6:0] e,
                        input logic [6:0] m = 7'h7f);
        exp_t x;
        x.tag  = tag;
        x.exp  = e;
        x.mask = m;
        sb.push_back(x);
        @(negedge clk);
        x = sb.pop_front();
        cmp(x.tag, 32'(outv & x.mask), 32'(x.exp & x.mask));
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic h0, input logic h1,
                          input logic l, input logic pr);
        mem_read  = mr;
        hit_0     = h0;
        hit_1     = h1;
        lru       = l;
        pmem_resp = pr;
    endtask

    // Response cycle: pmem_read value is not checked there.
    localparam logic [6:0] NO_PR = 7'h7e;

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp("rst_hit_count", 32'(hit_count), 32'd0);
        cmp("rst_miss_count", 32'(miss_count), 32'd0);
        step("rst_outputs", ov(0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Cold miss, lru=0, pmem responds after 5 waiting cycles
        set_in(1, 0, 0, 0, 0);
        step("cold_detect", ov(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) step("cold_wait", ov(0, 0, 0, 0, 0, 0, 1));
        pmem_resp = 1'b1;
        step("cold_fill", ov(1, 1, 1, 0, 1, 0, 0), NO_PR);
        set_in(0, 0, 0, 1, 0);
        cmp("cold_miss_count", 32'(miss_count), 32'd1);
        cmp("cold_hit_count", 32'(hit_count), 32'd0);

        // Hit in way 1
        set_in(1, 0, 1, 0, 0);
        step("hit1", ov(1, 0, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0);
        cmp("hit1_count", 32'(hit_count), 32'd1);

        // Second miss, victim way 1; lru flips to 0 while waiting
        set_in(1, 0, 0, 1, 0);
        step("miss2_detect", ov(0, 1, 0, 0, 0, 0, 0));
        lru = 1'b0;
        for (int i = 0; i < 3; i++) step("miss2_wait", ov(0, 0, 0, 0, 0, 0, 1));
        pmem_resp = 1'b1;
        step("miss2_fill", ov(1, 0, 0, 1, 0, 1, 0), NO_PR);
        set_in(0, 0, 0, 0, 0);
        cmp("miss2_count", 32'(miss_count), 32'd2);

        // Hit in way 0, then the illegal double hit treated as way 0
        set_in(1, 1, 0, 0, 0);
        step("hit0", ov(1, 1, 0, 0, 0, 0, 0));
        set_in(1, 1, 1, 0, 0);
        step("hit_both", ov(1, 1, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0);
        cmp("hit_count_3", 32'(hit_count), 32'd3);

        // Idle cycles pass lru through, no strobes
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("idle", ov(0, 1, 0, 0, 0, 0, 0));

        // mem_read dropped during the miss: fill still completes
        set_in(1, 0, 0, 0, 0);
        step("drop_detect", ov(0, 0, 0, 0, 0, 0, 0));
        mem_read = 1'b0;
        for (int i = 0; i < 2; i++) step("drop_wait", ov(0, 0, 0, 0, 0, 0, 1));
        pmem_resp = 1'b1;
        step("drop_fill", ov(1, 1, 1, 0, 1, 0, 0), NO_PR);
        set_in(0, 0, 0, 0, 0);
        cmp("drop_miss_count", 32'(miss_count), 32'd3);
        cmp("drop_hit_count", 32'(hit_count), 32'd3);

        // Reset asserted mid-miss
        set_in(1, 0, 0, 1, 0);
        step("rmiss_detect", ov(0, 1, 0, 0, 0, 0, 0));
        step("rmiss_wait", ov(0, 1, 0, 0, 0, 0, 1));
        rst_n = 1'b0;
        step("rmiss_rst_a", ov(0, 1, 0, 0, 0, 0, 0));
        step("rmiss_rst_b", ov(0, 1, 0, 0, 0, 0, 0));
        cmp("rmiss_hit_count", 32'(hit_count), 32'd0);
        cmp("rmiss_miss_count", 32'(miss_count), 32'd0);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 1);
        step("rmiss_no_fill", ov(0, 0, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0);
        cmp("rmiss_miss_after", 32'(miss_count), 32'd0);

        // Hit counter saturation
        set_in(1, 0, 1, 1, 0);
        for (int i = 0; i < 15; i++) step("sat_hit", ov(1, 0, 0, 0, 0, 0, 0));
        cmp("sat_reach", 32'(hit_count), 32'd15);
        step("sat_extra", ov(1, 0, 0, 0, 0, 0, 0));
        cmp("sat_hold", 32'(hit_count), 32'd15);

        // One miss so both counters are nonzero before the clear
        set_in(1, 0, 0, 0, 0);
        step("clr_miss_detect", ov(0, 0, 0, 0, 0, 0, 0));
        pmem_resp = 1'b1;
        step("clr_miss_fill", ov(1, 1, 1, 0, 1, 0, 0), NO_PR);
        set_in(0, 0, 0, 0, 0);
        cmp("clr_pre_miss", 32'(miss_count), 32'd1);

        // perf_clr wins over a same-cycle hit
        set_in(1, 1, 0, 0, 0);
        perf_clr = 1'b1;
        step("clr_hit", ov(1, 1, 0, 0, 0, 0, 0));
        perf_clr = 1'b0;
        cmp("clr_hit_count", 32'(hit_count), 32'd0);
        cmp("clr_miss_count", 32'(miss_count), 32'd0);
        step("post_clr_hit", ov(1, 1, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0);
        cmp("post_clr_count", 32'(hit_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
